// File: rtl/kb_pkg.sv
// kb_pkg: shared types and constants for the PS/2 keyboard event port.
package kb_pkg;

    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } kb_event_t;

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam logic [7:0] KB_EXT   = 8'hE0;
    localparam logic [7:0] KB_BREAK = 8'hF0;

    typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} kb_state_t;

endpackage

// File: rtl/kb_event_fifo.sv
// kb_event_fifo: synchronous key-event FIFO with flush; push while full succeeds only alongside a pop.
module kb_event_fifo
    import kb_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  kb_event_t        i_data,
    output kb_event_t        o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int AW = $clog2(DEPTH);

    kb_event_t        r_mem [DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push, w_do_pop;

    assign o_full    = r_count == CNT_W'(DEPTH);
    assign o_empty   = r_count == '0;
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rptr];
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
    assign w_do_push = i_push & (~o_full | w_do_pop) & ~i_flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/kb_event_port.sv
// kb_event_port: PS/2 scancode decoder and memory-mapped event FIFO.
// Define KB_BREAK_FILTER_EN to discard break events instead of queueing them.
module kb_event_port
    import kb_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  kb_code,
    input  logic        kb_flag,
    input  logic        sel,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic        re,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    output logic        overflow
);

    logic [2:0]       r_sync;
    kb_state_t        r_state, w_state_nxt;
    logic             r_irq, r_overflow;
    logic             w_rise, w_brk_st, w_ext_st, w_emit, w_push_req, w_push;
    logic             w_pop, w_flush, w_ovf_clr, w_ovf_set, w_do_push, w_irq_nxt;
    logic             w_ctrl_wr, w_full, w_empty, w_unused;
    logic [CNT_W-1:0] w_count;
    kb_event_t        w_event, w_head;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync     <= '0;
            r_state    <= IDLE;
            r_irq      <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_sync     <= {r_sync[1:0], kb_flag};
            r_state    <= w_state_nxt;
            r_irq      <= w_irq_nxt;
            r_overflow <= w_ovf_set | (r_overflow & ~w_ovf_clr);
        end
    end

    assign w_rise   = r_sync[1] & ~r_sync[2];
    assign w_brk_st = (r_state == GOT_F0) || (r_state == GOT_E0F0);
    assign w_ext_st = (r_state == GOT_E0) || (r_state == GOT_E0F0);

    // A second prefix of either kind merges into GOT_E0F0 once the other is already held.
    always_comb begin
        w_event     = '{brk: w_brk_st, ext: w_ext_st, code: kb_code};
        w_emit      = w_rise && kb_code != KB_EXT && kb_code != KB_BREAK;
        w_state_nxt = !w_rise               ? r_state :
                      kb_code == KB_EXT     ? (w_brk_st ? GOT_E0F0 : GOT_E0) :
                      kb_code == KB_BREAK   ? (w_ext_st ? GOT_E0F0 : GOT_F0) :
                                              IDLE;
    end

`ifdef KB_BREAK_FILTER_EN
    assign w_push_req = w_emit & ~w_event.brk;
`else
    assign w_push_req = w_emit;
`endif

    assign w_ctrl_wr = sel & we & (addr == REG_CTRL);
    assign w_flush   = w_ctrl_wr & wdata[1];
    assign w_ovf_clr = w_ctrl_wr & wdata[0];
    assign w_unused  = ^wdata[31:2];
    assign w_pop     = sel & re & (addr == REG_DATA) & ~w_empty & ~w_flush;
    assign w_push    = w_push_req & ~w_flush;
    assign w_do_push = w_push & (~w_full | w_pop);
    assign w_ovf_set = w_push & w_full & ~w_pop;
    assign w_irq_nxt = w_flush ? 1'b0 :
                       w_do_push ? 1'b1 :
                       (w_pop && w_count == CNT_W'(1)) ? 1'b0 : ~w_empty;

    kb_event_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  (w_event),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        rdata = !sel ? 32'h0 :
                addr == REG_STATUS ? {16'h0, 8'(w_count), 5'h0, r_overflow, w_full, ~w_empty} :
                (addr == REG_DATA && !w_empty) ? {1'b1, 21'h0, w_head} :
                32'h0;
    end

    assign irq      = r_irq;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_kb_event_port.sv
// tb_kb_event_port: directed vector table plus hand-built sequences for kb_event_port (DEPTH=8).
module tb_kb_event_port;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  kb_code = '0;
    logic        kb_flag = 1'b0;
    logic        sel = 1'b0;
    logic [1:0]  addr = '0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq, overflow;

    int n_chk = 0;
    int n_fail = 0;

    kb_event_port #(.DEPTH(8)) dut (
        .clk(clk), .reset(reset), .kb_code(kb_code), .kb_flag(kb_flag),
        .sel(sel), .addr(addr), .we(we), .re(re), .wdata(wdata),
        .rdata(rdata), .irq(irq), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [7:0]  b0, b1, b2;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] c);
        @(negedge clk);
        kb_code = c;
        kb_flag = 1'b1;
        repeat (4) @(negedge clk);
        kb_flag = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] a, input logic p, output logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; addr = a; re = p;
        #1 d = rdata;
        @(negedge clk);
        sel = 1'b0; re = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; addr = a; we = 1'b1; wdata = d;
        @(negedge clk);
        sel = 1'b0; we = 1'b0; wdata = '0;
    endtask

    initial begin
        vec_t        vecs[7];
        logic [7:0]  seq[3];
        logic [31:0] d, e;

        vecs[0] = '{1, 8'h23, 8'h00, 8'h00, 32'h8000_0023};
        vecs[1] = '{2, 8'hF0, 8'h23, 8'h00, 32'h8000_0223};
        vecs[2] = '{3, 8'hE0, 8'hF0, 8'h75, 32'h8000_0375};
        vecs[3] = '{2, 8'hE0, 8'h75, 8'h00, 32'h8000_0175};
        vecs[4] = '{3, 8'hE0, 8'hE0, 8'h14, 32'h8000_0114};
        vecs[5] = '{3, 8'hF0, 8'hF0, 8'h1C, 32'h8000_021C};
        vecs[6] = '{3, 8'hF0, 8'hE0, 8'h6B, 32'h8000_036B};

        repeat (3) @(negedge clk);
        check("reset_status", rdata, 32'h0);
        check("reset_irq", {31'h0, irq}, 32'h0);
        check("reset_ovf", {31'h0, overflow}, 32'h0);
        reset = 1'b1;
        rd(2'd0, 1'b0, d);
        check("reset_status_rd", d, 32'h0);

        for (int i = 0; i < 7; i++) begin
            seq = '{vecs[i].b0, vecs[i].b1, vecs[i].b2};
            e = vecs[i].exp;
`ifdef KB_BREAK_FILTER_EN
            if (e[9]) e = 32'h0;
`endif
            for (int j = 0; j < vecs[i].n; j++) send(seq[j]);
            rd(2'd0, 1'b0, d);
            check($sformatf("vec%0d_status_pre", i), d, e[31] ? 32'h0000_0101 : 32'h0);
            rd(2'd1, 1'b1, d);
            check($sformatf("vec%0d_data", i), d, e);
            rd(2'd0, 1'b0, d);
            check($sformatf("vec%0d_status_post", i), d, 32'h0);
        end

        // irq latency: push lands on the 3rd edge after kb_flag is sampled high
        @(negedge clk);
        kb_code = 8'h2A; kb_flag = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 check("lat_irq_edge2", {31'h0, irq}, 32'h0);
        @(posedge clk);
        #1 check("lat_irq_edge3", {31'h0, irq}, 32'h1);
        @(negedge clk);
        kb_flag = 1'b0;
        repeat (4) @(negedge clk);
        rd(2'd1, 1'b1, d);
        check("lat_data", d, 32'h8000_002A);
        check("lat_irq_after_pop", {31'h0, irq}, 32'h0);

        for (int i = 1; i <= 9; i++) send(8'(i));
        rd(2'd0, 1'b0, d);
        check("ovf_status", d, 32'h0000_0807);
        check("ovf_flag", {31'h0, overflow}, 32'h1);
        for (int i = 1; i <= 8; i++) begin
            rd(2'd1, 1'b1, d);
            check($sformatf("ovf_drain%0d", i), d, 32'h8000_0000 | 32'(i));
        end
        rd(2'd0, 1'b0, d);
        check("ovf_status_drained", d, 32'h0000_0004);
        wr(2'd2, 32'h1);
        rd(2'd0, 1'b0, d);
        check("ovf_cleared_status", d, 32'h0);
        check("ovf_cleared_flag", {31'h0, overflow}, 32'h0);

        for (int i = 0; i < 8; i++) send(8'h11 + 8'(i));
        @(negedge clk);
        kb_code = 8'h19; kb_flag = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        sel = 1'b1; addr = 2'd1; re = 1'b1;
        #1 check("pp_head", rdata, 32'h8000_0011);
        @(posedge clk);
        @(negedge clk);
        sel = 1'b0; re = 1'b0; kb_flag = 1'b0;
        rd(2'd0, 1'b0, d);
        check("pp_status", d, 32'h0000_0803);
        check("pp_ovf", {31'h0, overflow}, 32'h0);
        rd(2'd1, 1'b0, d);
        check("pp_new_head", d, 32'h8000_0012);
        for (int i = 0; i < 8; i++) begin
            rd(2'd1, 1'b1, d);
            check($sformatf("pp_drain%0d", i), d, 32'h8000_0012 + 32'(i));
        end

        send(8'hE0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        send(8'h23);
        rd(2'd1, 1'b1, d);
        check("rst_prefix_dropped", d, 32'h8000_0023);

        send(8'h1C); send(8'h32); send(8'h21);
        rd(2'd0, 1'b0, d);
        check("flush_pre", d, 32'h0000_0301);
        wr(2'd2, 32'h2);
        rd(2'd0, 1'b0, d);
        check("flush_status", d, 32'h0);
        check("flush_irq", {31'h0, irq}, 32'h0);

        rd(2'd1, 1'b1, d);
        check("empty_data", d, 32'h0);
        rd(2'd0, 1'b0, d);
        check("empty_status", d, 32'h0);
        send(8'h4B);
        rd(2'd3, 1'b0, d);
        check("addr3", d, 32'h0);
        rd(2'd2, 1'b0, d);
        check("ctrl_read", d, 32'h0);
        @(negedge clk);
        sel = 1'b0; addr = 2'd0;
        #1 check("sel_low", rdata, 32'h0);
        rd(2'd1, 1'b1, d);
        check("last_data", d, 32'h8000_004B);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/kb_event_port.md
# kb_event_port

Memory-mapped PS/2 keyboard event port between the keyboard controller and the ARMv4 processor data bus; replaces the single latched scancode word at RAM word 1. Synchronises the controller's `flag`/`KB_CODE` pair into the processor clock domain. Decodes make/break and extended prefixes into 10-bit key events and buffers them in a parametrised FIFO that software drains through status/data/control registers.

## Interface

Parameters:
- DEPTH, 8: FIFO entries. Power of two, at least 2.
- CNT_W, $clog2(DEPTH)+1: occupancy counter width. Derived; do not override.

Ports:
- clk  in  1  processor clock (`n25MHZCLK` at top level); all state on rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- kb_code  in  8  scancode byte from keyboard controller; stable while kb_flag high.
- kb_flag  in  1  keyboard-controller byte-valid level, asynchronous to clk.
- sel  in  1  bus chip select for this port.
- addr  in  2  word offset: 0 STATUS, 1 DATA, 2 CTRL, 3 reserved (reads 0).
- we  in  1  write strobe, qualified by sel.
- re  in  1  read strobe, qualified by sel; only affects state at DATA.
- wdata  in  32  write data.
- rdata  out  32  combinational read data; 0 when sel low.
- irq  out  1  registered; high while FIFO non-empty.
- overflow  out  1  registered sticky overflow flag.

## Operation

- Input path: 2-flop synchroniser on kb_flag, then a rising-edge detector. kb_code is sampled on the detected edge only.
- Decoder FSM, states IDLE, GOT_E0, GOT_F0, GOT_E0F0:
  - IDLE: 8'hE0 -> GOT_E0; 8'hF0 -> GOT_F0; other byte -> emit {brk=0, ext=0, code}.
  - GOT_E0: F0 -> GOT_E0F0; E0 -> stay; other byte -> emit {0, 1, code} and return to IDLE.
  - GOT_F0: F0 -> stay; E0 -> GOT_E0F0; other byte -> emit {1, 0, code} and return to IDLE.
  - GOT_E0F0: E0 or F0 -> stay; other byte -> emit {1, 1, code} and return to IDLE.
- Event format: bits [7:0] code, bit 8 ext, bit 9 brk.
- FIFO behaviour:
  - Emitted event is pushed.
  - Push while full with no pop: event dropped, overflow set.
  - Push and pop in the same cycle while full: both happen; count unchanged; no overflow.
- STATUS read: bit 0 not_empty, bit 1 full, bit 2 overflow, bits [15:8] count (zero-extended); other bits 0.
- DATA read: bit 31 valid, bits [9:0] head event. A read with re high pops the FIFO.
  - Read of DATA when empty returns 0 and changes no state (no underflow).
- CTRL write: bit 0 clears overflow, bit 1 flushes the FIFO. CTRL reads 0.
- Simultaneous events:
  - Flush and push in the same cycle: flush wins, event dropped, overflow unchanged.
  - Overflow clear and overflow set in the same cycle: set wins.
- Reset:
  - Values: FSM IDLE, FIFO empty, count 0, overflow 0, irq 0, synchroniser 0.
  - A prefix in progress at reset is discarded.

## Timing

- kb_flag rise to event in FIFO: push occurs on the 3rd rising clk edge after the flag is sampled high. irq is high the cycle after the push.
- kb_flag must stay low at least 3 clk cycles between bytes. The PS/2 byte rate guarantees this.
- Pop takes effect at the clk edge ending the read cycle. The next head event is visible combinationally on rdata in the following cycle.
- irq and overflow are registered: they reflect the state after the current edge.

## Configuration

- KB_BREAK_FILTER_EN
  - Defined: events with brk=1 are never pushed; they consume their prefixes and cannot cause overflow.
  - Undefined: all events are pushed as described above.

## Structure

- Package kb_pkg:
  - kb_event_t, a packed struct {brk, ext, code[7:0]}.
  - Register offsets REG_STATUS=0, REG_DATA=1, REG_CTRL=2.
  - Prefix constants KB_EXT=8'hE0 and KB_BREAK=8'hF0.
  - FSM state enum.
- One sub-module, kb_event_fifo: parametrised synchronous FIFO with push, pop, flush, full, empty and count. Holds DEPTH entries, each kb_event_t wide, using wrapping pointers.

## Test plan

- Byte 8'h23 -> DATA reads 32'h8000_0023; STATUS bit 0 is high before the read and 0 after.
- Bytes F0, 23 -> DATA 32'h8000_0223. Bytes E0, F0, 75 -> DATA 32'h8000_0375. With KB_BREAK_FILTER_EN defined, both sequences leave the FIFO empty.
- DEPTH=8, 9 make codes 01..09 -> STATUS count 8, full 1, overflow 1. Drain returns 01..08 in order; a CTRL write of 1 clears overflow.
- FIFO full while a pop and a push land in the same cycle -> count stays 8, overflow stays 0, head advances.
- Reset asserted after the E0 prefix, then byte 23 -> DATA 32'h8000_0023 (no ext bit). A CTRL write of 2 with 3 events queued -> count 0, irq 0.
- DATA read on an empty FIFO -> rdata 0, count 0, no state change. addr 3 -> rdata 0.
